// File: rtl/traffic_phase_scheduler.sv
// Purpose: demand-driven phase scheduler for a two-road intersection with an optional walk phase.
// Latency: IDLE->G1 one cycle after enable is sampled high; all other transitions land on a 1 s tick edge.
// Backpressure: none; sensor inputs are level samples and the lamp outputs are a Moore decode of state.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   enable                    1 = run, 0 = wind down to IDLE through yellow/all-red
//   req1, req2                vehicle presence per road (level)
//   ped_req                   pedestrian button (pulse or level)
//   road1_out, road2_out      one-hot lamp codes RED=001 YELLOW=010 GREEN=100
//   walk_out                  walk lamp
//   phase_tick                one-cycle 1 s tick pulse (debug)
//
// Optional feature: define PED_CROSSING_EN to build the pedestrian request latch and WALK phase.
// Without it, ped_req is ignored and WALK is unreachable.

module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 40000000,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       enable,
  input  logic       req1,
  input  logic       req2,
  input  logic       ped_req,
  output logic [2:0] road1_out,
  output logic [2:0] road2_out,
  output logic       walk_out,
  output logic       phase_tick
);

  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_G1,
    S_Y1,
    S_AR1,
    S_G2,
    S_Y2,
    S_AR2,
    S_WALK
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [4:0]    el;
  logic [5:0]    el_inc;
  logic          ped_pend;
  logic          road2_next;   // 1: next green after WALK is road 2

  // ---------------------------------------------------------------------------
  // 1 s prescaler. Held at 0 in IDLE so the first tick lands exactly TICK_DIV
  // cycles after leaving IDLE; every transition happens on a wrap, so each
  // new phase also starts with the counter at 0.
  // ---------------------------------------------------------------------------
  assign tick       = (state != S_IDLE) && (cnt == CNT_MAX);
  assign phase_tick = tick;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state == S_IDLE) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Phase timer: cleared on any state change (this wins over a coincident
  // tick), otherwise counts ticks and saturates at 31.
  // ---------------------------------------------------------------------------
  assign el_inc = {1'b0, el} + 6'd1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      el <= '0;
    end else if (state_nx != state) begin
      el <= '0;
    end else if (tick && el != 5'd31) begin
      el <= el + 5'd1;
    end
  end

  // "Expiring" predicates: this tick completes the stated number of ticks.
  logic min_ok, max_ok, yel_done, ar_done, walk_done;
  assign min_ok    = tick && (el_inc >= 6'(MIN_GREEN));
  assign max_ok    = tick && (el_inc >= 6'(MAX_GREEN));
  assign yel_done  = tick && (el_inc >= 6'(YELLOW_T));
  assign ar_done   = tick && (el_inc >= 6'(ALLRED_T));
  assign walk_done = tick && (el_inc >= 6'(WALK_T));

  // ---------------------------------------------------------------------------
  // Pedestrian request latch. Cleared on the edge entering WALK; a press on
  // that same edge is dropped, a press during WALK re-arms it.
  // ---------------------------------------------------------------------------
`ifdef PED_CROSSING_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ped_pend <= 1'b0;
    end else if (state_nx == S_WALK && state != S_WALK) begin
      ped_pend <= 1'b0;
    end else if (ped_req) begin
      ped_pend <= 1'b1;
    end
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
`endif

  // Road to serve after a walk phase: the one opposite the all-red just left.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      road2_next <= 1'b1;
    end else if (state == S_AR1 && state_nx != S_AR1) begin
      road2_next <= 1'b1;
    end else if (state == S_AR2 && state_nx != S_AR2) begin
      road2_next <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  logic comp1, comp2;
  assign comp1 = req2 | ped_pend;   // demand competing with road 1 green
  assign comp2 = req1 | ped_pend;   // demand competing with road 2 green

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (enable) state_nx = S_G1;
      end
      // Gap-out, max-out, or wind-down once minimum green is served.
      S_G1: begin
        if ((min_ok && comp1 && !req1) || (max_ok && comp1) || (min_ok && !enable))
          state_nx = S_Y1;
      end
      S_Y1: begin
        if (yel_done) state_nx = S_AR1;
      end
      S_AR1: begin
        if (ar_done) begin
          if (ped_pend)     state_nx = S_WALK;
          else if (!enable) state_nx = S_IDLE;
          else              state_nx = S_G2;
        end
      end
      S_G2: begin
        if ((min_ok && comp2 && !req2) || (max_ok && comp2) || (min_ok && !enable))
          state_nx = S_Y2;
      end
      S_Y2: begin
        if (yel_done) state_nx = S_AR2;
      end
      S_AR2: begin
        if (ar_done) begin
          if (ped_pend)     state_nx = S_WALK;
          else if (!enable) state_nx = S_IDLE;
          else              state_nx = S_G1;
        end
      end
      S_WALK: begin
        if (walk_done) begin
          if (!enable)         state_nx = S_IDLE;
          else if (road2_next) state_nx = S_G2;
          else                 state_nx = S_G1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Moore lamp decode
  // ---------------------------------------------------------------------------
  always_comb begin
    road1_out = LAMP_RED;
    road2_out = LAMP_RED;
    walk_out  = 1'b0;
    case (state)
      S_G1: road1_out = LAMP_GREEN;
      S_Y1: road1_out = LAMP_YELLOW;
      S_G2: road2_out = LAMP_GREEN;
      S_Y2: road2_out = LAMP_YELLOW;
`ifdef PED_CROSSING_EN
      S_WALK: walk_out = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Purpose: directed bench for traffic_phase_scheduler with TICK_DIV=4.
// Latency: samples taken 1 time unit after each rising edge.
// Backpressure: none.

module tb_traffic_phase_scheduler;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       enable;
  logic       req1;
  logic       req2;
  logic       ped_req;
  logic [2:0] road1_out;
  logic [2:0] road2_out;
  logic       walk_out;
  logic       phase_tick;

  int checks = 0;
  int errors = 0;
  logic bad;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  traffic_phase_scheduler #(
    .TICK_DIV (4),
    .MIN_GREEN(5),
    .MAX_GREEN(10),
    .YELLOW_T (2),
    .ALLRED_T (1),
    .WALK_T   (8)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .enable    (enable),
    .req1      (req1),
    .req2      (req2),
    .ped_req   (ped_req),
    .road1_out (road1_out),
    .road2_out (road2_out),
    .walk_out  (walk_out),
    .phase_tick(phase_tick)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    enable   = 1'b0;
    req1     = 1'b0;
    req2     = 1'b0;
    ped_req  = 1'b0;
    step(2);
    wb_rst_i = 1'b0;
  endtask

  initial begin
    // ---------------- reset and first green ----------------
    do_reset();
    chk("rst_road1", road1_out, R);
    chk("rst_road2", road2_out, R);
    chk("rst_walk", walk_out, 1'b0);
    chk("rst_tick", phase_tick, 1'b0);
    enable = 1'b1;
    req1   = 1'b1;
    step(1);
    chk("idle_to_g1_road1", road1_out, G);
    chk("idle_to_g1_road2", road2_out, R);

    // ---------------- rest in green ----------------
    bad = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (road1_out !== G || road2_out !== R) bad = 1'b1;
    end
    chk("rest_green_400", bad, 1'b0);

    // ---------------- gap-out then wind-down from G2 ----------------
    do_reset();
    enable = 1'b1;
    req2   = 1'b1;
    step(1);                                   // sample 0: G1
    chk("gap_g1_entry", road1_out, G);
    step(2);                                   // sample 2
    chk("gap_tick_s2", phase_tick, 1'b0);
    step(1);                                   // sample 3: first tick
    chk("gap_tick_s3", phase_tick, 1'b1);
    step(16);                                  // sample 19
    chk("gap_g1_last", road1_out, G);
    step(1);                                   // sample 20
    chk("gap_y1_road1", road1_out, Y);
    chk("gap_y1_road2", road2_out, R);
    step(7);                                   // sample 27
    chk("gap_y1_last", road1_out, Y);
    step(1);                                   // sample 28
    chk("gap_ar1_road1", road1_out, R);
    chk("gap_ar1_road2", road2_out, R);
    step(3);                                   // sample 31
    chk("gap_ar1_last", road2_out, R);
    step(1);                                   // sample 32: G2
    chk("gap_g2_road2", road2_out, G);
    chk("gap_g2_road1", road1_out, R);
    step(28);                                  // sample 60: el=7 in G2
    chk("wd_g2_el7", road2_out, G);
    enable = 1'b0;
    step(3);                                   // sample 63
    chk("wd_g2_last", road2_out, G);
    step(1);                                   // sample 64
    chk("wd_y2", road2_out, Y);
    step(8);                                   // sample 72
    chk("wd_ar2_road1", road1_out, R);
    chk("wd_ar2_road2", road2_out, R);
    step(3);                                   // sample 75: AR2 tick
    chk("wd_ar2_tick", phase_tick, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (phase_tick !== 1'b0 || road1_out !== R || road2_out !== R) bad = 1'b1;
    end
    chk("wd_idle_held", bad, 1'b0);
    enable = 1'b1;
    step(1);
    chk("wd_restart_g1", road1_out, G);

    // ---------------- max-out ----------------
    do_reset();
    enable = 1'b1;
    req1   = 1'b1;
    req2   = 1'b1;
    step(1);                                   // sample 0
    step(20);                                  // sample 20: no gap-out
    chk("max_g1_s20", road1_out, G);
    step(19);                                  // sample 39
    chk("max_g1_last", road1_out, G);
    step(1);                                   // sample 40
    chk("max_y1", road1_out, Y);
    step(12);                                  // sample 52
    chk("max_g2", road2_out, G);

    // ---------------- reset mid-Y1 ----------------
    do_reset();
    enable = 1'b1;
    req2   = 1'b1;
    step(1);
    step(22);                                  // sample 22: Y1
    chk("midy_y1", road1_out, Y);
    wb_rst_i = 1'b1;
    step(1);
    chk("midy_rst_road1", road1_out, R);
    chk("midy_rst_road2", road2_out, R);
    chk("midy_rst_walk", walk_out, 1'b0);
    wb_rst_i = 1'b0;
    step(1);
    chk("midy_restart_g1", road1_out, G);

    // ---------------- pedestrian ----------------
    do_reset();
    enable = 1'b1;
    step(1);                                   // sample 0: G1
    step(3);                                   // sample 3
    ped_req = 1'b1;
    step(1);                                   // sample 4
    ped_req = 1'b0;
`ifdef PED_CROSSING_EN
    step(15);                                  // sample 19
    chk("ped_g1_last", road1_out, G);
    step(1);                                   // sample 20
    chk("ped_y1", road1_out, Y);
    step(8);                                   // sample 28
    chk("ped_ar1_road1", road1_out, R);
    chk("ped_ar1_walk", walk_out, 1'b0);
    step(4);                                   // sample 32
    chk("ped_walk_on", walk_out, 1'b1);
    chk("ped_walk_road1", road1_out, R);
    chk("ped_walk_road2", road2_out, R);
    step(31);                                  // sample 63
    chk("ped_walk_last", walk_out, 1'b1);
    step(1);                                   // sample 64
    chk("ped_walk_off", walk_out, 1'b0);
    chk("ped_g2_road2", road2_out, G);
    chk("ped_g2_road1", road1_out, R);
`else
    step(60);                                  // sample 64
    chk("noped_road1", road1_out, G);
    chk("noped_road2", road2_out, R);
    chk("noped_walk", walk_out, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
